lcd_window_blit: RTL and testbench

Pixel stage between the LCD sync/timing generator and the RGB565 panel pins. It consumes the generator's DEN/HSYNC/VSYNC and tracks its own active-area column and row. It fetches a scaled image window from a synchronous ROM such as `image_rom`, and emits delay-matched sync, DEN and RGB565 pixel data, with a gradient background outside the window.

---
 rtl/lcd_window_blit_if.sv | 26 ++
 rtl/lcd_window_blit.sv | 113 +++++++++++
 tb/tb_lcd_window_blit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_window_blit_if.sv
// Bundles the sync/DEN input, ROM fetch port and RGB565 panel output of the window blitter.
interface lcd_window_blit_if #(
  parameter int ADDR_W = 12
);
  logic              in_den;
  logic              in_hsync;
  logic              in_vsync;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              out_den;
  logic              out_hsync;
  logic              out_vsync;
  logic [4:0]        out_r;
  logic [5:0]        out_g;
  logic [4:0]        out_b;

  modport master (
    input  in_den, in_hsync, in_vsync, rom_data,
    output rom_addr, out_den, out_hsync, out_vsync, out_r, out_g, out_b
  );

  modport slave (
    output in_den, in_hsync, in_vsync, rom_data,
    input  rom_addr, out_den, out_hsync, out_vsync, out_r, out_g, out_b
  );
endinterface

// File: rtl/lcd_window_blit.sv
// Places a scaled ROM image window on a gradient background, keeping sync, DEN
// and color aligned through a fixed ROM_LAT+2 cycle pipeline.
module lcd_window_blit #(
  parameter int WIN_X      = 112,
  parameter int WIN_Y      = 8,
  parameter int WIN_LOG2   = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int ROM_LAT    = 1,
  parameter int ADDR_W     = 2*(WIN_LOG2-SCALE_LOG2)
) (
  input  logic clk,
  input  logic reset,
  lcd_window_blit_if.master bus
);
  localparam int DEPTH = ROM_LAT + 2;
  localparam int TAP   = ROM_LAT + 1;

  logic [10:0]       col;
  logic [9:0]        row;
  logic              locked;
  logic              den_d;
  logic              vsync_d;
  logic [10:0]       rx;
  logic [9:0]        ry;
  logic              hit;
  logic              den_fall;
  logic              vsync_fall;
  logic [15:0]       grad;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_s0;
  logic [DEPTH-1:0]  hit_p;
  logic [DEPTH-1:0]  den_p;
  logic [DEPTH-1:0]  hs_p;
  logic [DEPTH-1:0]  vs_p;
  logic [15:0]       grad_p [DEPTH];
  logic [15:0]       color;

  // Unsigned offsets: columns/rows left of or above the window wrap to large values and miss.
  always_comb begin
    rx         = col - 11'(WIN_X);
    ry         = row - 10'(WIN_Y);
    den_fall   = den_d & ~bus.in_den;
    vsync_fall = vsync_d & ~bus.in_vsync;
    hit        = bus.in_den && locked
                 && ({1'b0, rx} < 12'(2**WIN_LOG2))
                 && ({2'b0, ry} < 12'(2**WIN_LOG2));
    addr       = ADDR_W'({ry[WIN_LOG2-1:SCALE_LOG2], rx[WIN_LOG2-1:SCALE_LOG2]});
    grad       = bus.in_den ? (16'(col) + 16'(row)) : 16'd0;
    color      = hit_p[TAP]
                 ? {bus.rom_data[4:0], bus.rom_data[5:0], bus.rom_data[4:0]}
                 : grad_p[TAP];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      locked  <= 1'b0;
      den_d   <= 1'b0;
      vsync_d <= 1'b1;
    end else begin
      den_d   <= bus.in_den;
      vsync_d <= bus.in_vsync;
      if (!bus.in_den)
        col <= '0;
      else if (col != 11'h7FF)
        col <= col + 11'd1;
      // A frame start outranks a line end that lands on the same cycle.
      if (vsync_fall) begin
        row    <= '0;
        locked <= 1'b1;
      end else if (den_fall && row != 10'h3FF) begin
        row <= row + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_p         <= '0;
      den_p         <= '0;
      hs_p          <= '1;
      vs_p          <= '1;
      addr_s0       <= '0;
      bus.rom_addr  <= '0;
      bus.out_den   <= 1'b0;
      bus.out_hsync <= 1'b1;
      bus.out_vsync <= 1'b1;
      bus.out_r     <= '0;
      bus.out_g     <= '0;
      bus.out_b     <= '0;
      for (int i = 0; i < DEPTH; i++) grad_p[i] <= '0;
    end else begin
      hit_p     <= {hit_p[DEPTH-2:0], hit};
      den_p     <= {den_p[DEPTH-2:0], bus.in_den};
      hs_p      <= {hs_p[DEPTH-2:0], bus.in_hsync};
      vs_p      <= {vs_p[DEPTH-2:0], bus.in_vsync};
      grad_p[0] <= grad;
      for (int i = 1; i < DEPTH; i++) grad_p[i] <= grad_p[i-1];
      if (hit)
        addr_s0 <= addr;
      // The ROM address leaves one cycle after sampling so ROM data meets hit_p[TAP].
      if (hit_p[0])
        bus.rom_addr <= addr_s0;
      bus.out_den   <= den_p[TAP];
      bus.out_hsync <= hs_p[TAP];
      bus.out_vsync <= vs_p[TAP];
      bus.out_r     <= color[4:0];
      bus.out_g     <= color[10:5];
      bus.out_b     <= color[15:11];
    end
  end
endmodule

// File: tb/tb_lcd_window_blit.sv
// Drives two blitters (ROM_LAT 1 and 2) with the same sync stream and checks them
// every cycle against a screen-coordinate model plus a few literal pixel values.
module tb_lcd_window_blit;
  localparam int WIN_X  = 112;
  localparam int WIN_Y  = 8;
  localparam int ADDR_W = 12;
  localparam int NE     = 65536;
  localparam int NP     = 11;

  typedef struct packed {
    logic        den;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } out_t;

  localparam out_t IDLE = {1'b0, 1'b1, 1'b1, 16'd0};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic den   = 1'b0;
  logic hsync = 1'b1;
  logic vsync = 1'b1;

  always #5 clk = ~clk;

  lcd_window_blit_if #(.ADDR_W(ADDR_W)) bus1 ();
  lcd_window_blit_if #(.ADDR_W(ADDR_W)) bus2 ();

  assign bus1.in_den   = den;
  assign bus1.in_hsync = hsync;
  assign bus1.in_vsync = vsync;
  assign bus2.in_den   = den;
  assign bus2.in_hsync = hsync;
  assign bus2.in_vsync = vsync;

  // ROM image: each texel's data is the low byte of its own address.
  logic [7:0] rom1_q;
  logic [7:0] rom2_a;
  logic [7:0] rom2_q;
  always @(posedge clk) rom1_q <= bus1.rom_addr[7:0];
  always @(posedge clk) begin
    rom2_a <= bus2.rom_addr[7:0];
    rom2_q <= rom2_a;
  end
  assign bus1.rom_data = rom1_q;
  assign bus2.rom_data = rom2_q;

  lcd_window_blit #(.WIN_X(112), .WIN_Y(8), .WIN_LOG2(8), .SCALE_LOG2(2),
                    .ROM_LAT(1), .ADDR_W(ADDR_W))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  lcd_window_blit #(.WIN_X(112), .WIN_Y(8), .WIN_LOG2(8), .SCALE_LOG2(2),
                    .ROM_LAT(2), .ADDR_W(ADDR_W))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  out_t              exp1 [NE];
  out_t              exp2 [NE];
  bit                v1   [NE];
  bit                v2   [NE];
  logic [ADDR_W-1:0] expa [NE];
  bit                va   [NE];

  int edge_cnt = 0;
  int total    = 0;
  int bad      = 0;

  int mcol  = 0;
  int mrow  = 0;
  int maddr = 0;
  bit mlocked = 1'b0;
  bit pden    = 1'b0;
  bit pvs     = 1'b1;

  int   cur_x = 0;
  int   cur_y = 0;
  bit   pin_on = 1'b0;
  int   pin_y    [NP];
  int   pin_x    [NP];
  int   pin_edge [NP];
  logic [15:0] pin_rgb [NP];
  int   chk_row_edge = -1;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [15:0] to_rgb(input logic [15:0] c);
    return {c[4:0], c[10:5], c[15:11]};
  endfunction

  task automatic checkOutput(input string name, input int e,
                             input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d actual=%h required=%h", name, e, act, req);
    end
  endtask

  // One input sample: records what every output must show L edges later.
  task automatic applyStimulus(input logic d, input logic h, input logic v, input logic r);
    int e, cc, rx, ry, a;
    bit hit;
    logic [15:0] c;
    logic [7:0] dd;
    out_t o;
    @(negedge clk);
    den = d; hsync = h; vsync = v; reset = r;
    e = edge_cnt + 1;
    if (r) begin
      for (int j = 0; j <= 4; j++) begin
        exp1[e+j] = IDLE; v1[e+j] = 1'b1;
        exp2[e+j] = IDLE; v2[e+j] = 1'b1;
      end
      expa[e] = '0; va[e] = 1'b1;
      expa[e+1] = '0; va[e+1] = 1'b1;
      mcol = 0; mrow = 0; maddr = 0; mlocked = 1'b0; pden = 1'b0; pvs = 1'b1;
    end else begin
      cc  = (mcol > 2047) ? 2047 : mcol;
      rx  = cc - WIN_X;
      ry  = mrow - WIN_Y;
      hit = d && mlocked && rx >= 0 && rx < 256 && ry >= 0 && ry < 256;
      if (hit) begin
        a = (ry / 4) * 64 + rx / 4;
        maddr = a;
        dd = 8'(a);
        c = {dd[4:0], dd[5:0], dd[4:0]};
      end else begin
        c = d ? 16'(cc + mrow) : 16'd0;
      end
      o = {d, h, v, to_rgb(c)};
      exp1[e+3] = o; v1[e+3] = 1'b1;
      exp2[e+4] = o; v2[e+4] = 1'b1;
      expa[e+1] = ADDR_W'(maddr); va[e+1] = 1'b1;
      if (pin_on && d)
        for (int i = 0; i < NP; i++)
          if (cur_y == pin_y[i] && cur_x == pin_x[i]) pin_edge[i] = e;
      if (pvs && !v) begin
        mrow = 0;
        mlocked = 1'b1;
      end else if (pden && !d && mrow < 1023) begin
        mrow++;
      end
      mcol = d ? mcol + 1 : 0;
      pden = d;
      pvs  = v;
    end
  endtask

  task automatic gen_blank(input bit vs_first);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, (b == 1 || b == 2) ? 1'b0 : 1'b1,
                    (vs_first && b == 0) ? 1'b0 : 1'b1, 1'b0);
      if (vs_first && b == 0) chk_row_edge = edge_cnt + 1;
    end
  endtask

  task automatic gen_line(input int y, input int w, input bit vs_end);
    cur_y = y;
    for (int x = 0; x < w; x++) begin
      cur_x = x;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    end
    gen_blank(vs_end);
  endtask

  task automatic gen_vsync();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Rows near the window's top and bottom edges are full width; the rest are short.
  task automatic gen_frame(input int first_y, input int last_y);
    for (int y = first_y; y <= last_y; y++)
      gen_line(y, ((y <= 13) || (y >= 262)) ? 380 : 4, 1'b0);
  endtask

  out_t a1;
  out_t a2;
  always @(negedge clk) begin
    a1 = {bus1.out_den, bus1.out_hsync, bus1.out_vsync, bus1.out_r, bus1.out_g, bus1.out_b};
    a2 = {bus2.out_den, bus2.out_hsync, bus2.out_vsync, bus2.out_r, bus2.out_g, bus2.out_b};
    if (v1[edge_cnt]) checkOutput("out_lat3", edge_cnt, 32'(a1), 32'(exp1[edge_cnt]));
    if (v2[edge_cnt]) checkOutput("out_lat4", edge_cnt, 32'(a2), 32'(exp2[edge_cnt]));
    if (va[edge_cnt]) begin
      checkOutput("addr_lat3", edge_cnt, 32'(bus1.rom_addr), 32'(expa[edge_cnt]));
      checkOutput("addr_lat4", edge_cnt, 32'(bus2.rom_addr), 32'(expa[edge_cnt]));
    end
    for (int i = 0; i < NP; i++) begin
      if (pin_edge[i] >= 0 && edge_cnt == pin_edge[i] + 3)
        checkOutput("pin_lat3", edge_cnt, 32'(a1.rgb), 32'(pin_rgb[i]));
      if (pin_edge[i] >= 0 && edge_cnt == pin_edge[i] + 4)
        checkOutput("pin_lat4", edge_cnt, 32'(a2.rgb), 32'(pin_rgb[i]));
    end
    if (edge_cnt == chk_row_edge) begin
      checkOutput("row_clear_lat3", edge_cnt, 32'(u_dut1.row), 32'd0);
      checkOutput("row_clear_lat4", edge_cnt, 32'(u_dut2.row), 32'd0);
    end
  end

  initial begin
    pin_y   = '{7, 8, 8, 8, 8, 8, 8, 12, 263, 263, 264};
    pin_x   = '{111, 111, 112, 116, 124, 367, 368, 112, 111, 367, 112};
    pin_rgb = '{{5'd22, 6'd3, 5'd0},  {5'd23, 6'd3, 5'd0},  {5'd0, 6'd0, 5'd0},
                {5'd1, 6'd1, 5'd1},   {5'd3, 6'd3, 5'd3},   {5'd31, 6'd63, 5'd31},
                {5'd24, 6'd11, 5'd0}, {5'd0, 6'd0, 5'd0},   {5'd22, 6'd11, 5'd0},
                {5'd31, 6'd63, 5'd31}, {5'd24, 6'd11, 5'd0}};
    for (int i = 0; i < NP; i++) pin_edge[i] = -1;

    for (int i = 0; i < 5; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1);

    // Unlocked lines reaching window rows and columns: gradient only.
    for (int y = 0; y < 10; y++) gen_line(y, 130, 1'b0);

    gen_vsync();
    pin_on = 1'b1;
    gen_frame(0, 265);
    pin_on = 1'b0;

    // Reset in the middle of a window line, released with DEN still high.
    gen_vsync();
    gen_frame(0, 9);
    cur_y = 10;
    for (int x = 0; x < 150; x++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int x = 0; x < 3; x++)   applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int x = 0; x < 200; x++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    gen_blank(1'b0);
    gen_frame(11, 265);

    // Relocked frame, ending with DEN and VSYNC falling together.
    gen_vsync();
    gen_frame(0, 264);
    gen_line(265, 380, 1'b1);

    // Over-long DEN on a window row: col must stick at 2047.
    for (int y = 0; y < 10; y++) gen_line(y, 4, 1'b0);
    gen_line(10, 2500, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
